// File: rtl/radar_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : radar_timing_pkg
//  Description : Shared sweep states, default timing constants and azimuth
//                width for the radar sweep scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package radar_timing_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TRIG  = 3'd1,
        S_BLANK = 3'd2,
        S_RANGE = 3'd3,
        S_DEAD  = 3'd4
    } sweep_state_e;

    localparam int DEF_PRI           = 24412;
    localparam int DEF_TRIG_HIGH     = 50;
    localparam int DEF_BLANK         = 100;
    localparam int DEF_NUM_BINS      = 1024;
    localparam int DEF_BIN_DIV       = 2;
    localparam int DEF_BIN_W         = 10;
    localparam int DEF_STAGGER_DELTA = 1000;

    localparam int AZ_W = 12;

endpackage
`default_nettype wire

// File: rtl/radar_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : radar_edge_det
//  Description : Registered rising-edge detector. The input is registered
//                once and the rise strobe is itself registered, so the strobe
//                appears one cycle after the input edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module radar_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic r_q;
    logic r_rise;

    // Previous-sample register and registered rise strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q    <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_q    <= din;
            r_rise <= din & ~r_q;
        end
    end

    assign rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/radar_sweep_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : radar_sweep_scheduler
//  Description : Locks to the ARP/ACP azimuth stream, issues the master
//                trigger once per PRI and sequences each sweep through
//                trigger, blanking, range gate and dead time, strobing one
//                bin_valid per range bin.
//  Options     : RADAR_STAGGER_EN - odd sweeps are STAGGER_DELTA cycles
//                longer (extra time lands in DEAD).
//  Revision    : 1.0 - initial release
// ============================================================================
module radar_sweep_scheduler
    import radar_timing_pkg::*;
#(
    parameter int PRI           = DEF_PRI,
    parameter int TRIG_HIGH     = DEF_TRIG_HIGH,
    parameter int BLANK         = DEF_BLANK,
    parameter int NUM_BINS      = DEF_NUM_BINS,
    parameter int BIN_DIV       = DEF_BIN_DIV,
    parameter int BIN_W         = DEF_BIN_W,
    parameter int STAGGER_DELTA = DEF_STAGGER_DELTA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              arp,
    input  logic              acp,
    output logic              trig,
    output logic              sweep_start,
    output logic              bin_valid,
    output logic [BIN_W-1:0]  bin_idx,
    output logic [AZ_W-1:0]   az_idx,
    output logic              locked,
    output logic              overrun,
    output logic              arp_err
);

    // Counter is sized for the longest possible (staggered) sweep
    localparam int CNT_W   = $clog2(PRI + STAGGER_DELTA + 1);
    localparam int SUB_MAX = (BLANK > BIN_DIV) ? BLANK : BIN_DIV;
    localparam int SUB_W   = $clog2(SUB_MAX + 1);

    localparam logic [CNT_W-1:0] c_pri_last   = CNT_W'(PRI - 1);
    localparam logic [CNT_W-1:0] c_trig_last  = CNT_W'(TRIG_HIGH - 1);
    localparam logic [SUB_W-1:0] c_blank_last = (BLANK > 0) ? SUB_W'(BLANK - 1) : '0;
    localparam logic [SUB_W-1:0] c_div_last   = SUB_W'(BIN_DIV - 1);
    localparam logic [BIN_W-1:0] c_bin_last   = BIN_W'(NUM_BINS - 1);

    sweep_state_e      r_state;
    logic [CNT_W-1:0]  r_pri_cnt;
    logic [SUB_W-1:0]  r_sub_cnt;
    logic [BIN_W-1:0]  r_bin_idx;
    logic [AZ_W-1:0]   r_az;
    logic              r_trig;
    logic              r_sweep_start;
    logic              r_bin_valid;
    logic              r_locked;
    logic              r_overrun;
    logic              r_arp_err;
    logic              r_arp_lvl;

    logic              w_arp_rise;
    logic              w_acp_rise;
    logic [CNT_W-1:0]  w_period_last;
    logic              w_expiry;
    logic              w_bin_end;
    logic              w_gate_done;

    radar_edge_det u_arp_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (arp),
        .rise (w_arp_rise)
    );

    radar_edge_det u_acp_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (acp),
        .rise (w_acp_rise)
    );

`ifdef RADAR_STAGGER_EN
    localparam logic [CNT_W-1:0] c_stagger = CNT_W'(STAGGER_DELTA);
    logic r_odd;

    // Odd/even sweep tracker; the first sweep after lock is even (plain PRI)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_odd <= 1'b0;
        end else if (!enable || r_state == S_IDLE) begin
            r_odd <= 1'b0;
        end else if (w_expiry) begin
            r_odd <= ~r_odd;
        end
    end

    assign w_period_last = r_odd ? (c_pri_last + c_stagger) : c_pri_last;
`else
    assign w_period_last = c_pri_last;
`endif

    assign w_expiry    = (r_state != S_IDLE) && (r_pri_cnt == w_period_last);
    assign w_bin_end   = (r_sub_cnt == c_div_last);
    assign w_gate_done = w_bin_end && (r_bin_idx == c_bin_last);

    // Sweep sequencer: state, PRI counter, bin counter and timing outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_pri_cnt     <= '0;
            r_sub_cnt     <= '0;
            r_bin_idx     <= '0;
            r_trig        <= 1'b0;
            r_sweep_start <= 1'b0;
            r_bin_valid   <= 1'b0;
            r_locked      <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_sweep_start <= 1'b0;
            r_bin_valid   <= 1'b0;
            if (!enable) begin
                r_state   <= S_IDLE;
                r_pri_cnt <= '0;
                r_sub_cnt <= '0;
                r_bin_idx <= '0;
                r_trig    <= 1'b0;
                r_locked  <= 1'b0;
            end else if (r_state == S_IDLE) begin
                if (w_arp_rise) begin
                    r_state       <= S_TRIG;
                    r_pri_cnt     <= '0;
                    r_trig        <= 1'b1;
                    r_sweep_start <= 1'b1;
                    r_locked      <= 1'b1;
                end
            end else if (w_expiry) begin
                // Free-running restart; a gate still open here is truncated
                r_state       <= S_TRIG;
                r_pri_cnt     <= '0;
                r_sub_cnt     <= '0;
                r_bin_idx     <= '0;
                r_trig        <= 1'b1;
                r_sweep_start <= 1'b1;
                if (r_state == S_RANGE && !w_gate_done) begin
                    r_overrun <= 1'b1;
                end
            end else begin
                r_pri_cnt <= r_pri_cnt + 1'b1;
                case (r_state)
                    S_TRIG: begin
                        if (r_pri_cnt == c_trig_last) begin
                            r_trig    <= 1'b0;
                            r_sub_cnt <= '0;
                            if (BLANK == 0) begin
                                r_state     <= S_RANGE;
                                r_bin_idx   <= '0;
                                r_bin_valid <= 1'b1;
                            end else begin
                                r_state <= S_BLANK;
                            end
                        end
                    end
                    S_BLANK: begin
                        if (r_sub_cnt == c_blank_last) begin
                            r_state     <= S_RANGE;
                            r_sub_cnt   <= '0;
                            r_bin_idx   <= '0;
                            r_bin_valid <= 1'b1;
                        end else begin
                            r_sub_cnt <= r_sub_cnt + 1'b1;
                        end
                    end
                    S_RANGE: begin
                        if (w_bin_end) begin
                            r_sub_cnt <= '0;
                            if (r_bin_idx == c_bin_last) begin
                                r_state   <= S_DEAD;
                                r_bin_idx <= '0;
                            end else begin
                                r_bin_idx   <= r_bin_idx + 1'b1;
                                r_bin_valid <= 1'b1;
                            end
                        end else begin
                            r_sub_cnt <= r_sub_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ARP level aligned with the ACP rise strobe (both one cycle behind input)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_arp_lvl <= 1'b0;
        end else begin
            r_arp_lvl <= arp;
        end
    end

    // Azimuth tracking and ARP position check; runs regardless of enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_az      <= '0;
            r_arp_err <= 1'b0;
        end else if (w_acp_rise) begin
            if (r_arp_lvl) begin
                r_az <= '0;
                if (r_locked && (r_az != '1)) begin
                    r_arp_err <= 1'b1;
                end
            end else begin
                r_az <= r_az + 1'b1;
            end
        end
    end

    assign trig        = r_trig;
    assign sweep_start = r_sweep_start;
    assign bin_valid   = r_bin_valid;
    assign bin_idx     = r_bin_idx;
    assign az_idx      = r_az;
    assign locked      = r_locked;
    assign overrun     = r_overrun;
    assign arp_err     = r_arp_err;

endmodule
`default_nettype wire
